// File: rtl/case_2_mul_pipe_hs.sv
// Multi-stage multiplier with a valid/ready handshake, wrap-or-saturate output
// formatting and a sticky overflow flag.
module case_2_mul_pipe_hs #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1,
  parameter int SAT        = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int PW = din0_WIDTH + din1_WIDTH + 1;
  localparam int DW = dout_WIDTH;
  localparam int EW = (PW > DW) ? PW : DW;
  localparam int PS = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
  localparam bit S0 = (SIGNED0 != 0);
  localparam bit S1 = (SIGNED1 != 0);
  localparam bit OUT_SIGNED = S0 | S1;
  localparam bit DO_SAT = (SAT != 0);
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] SMAX = ~SMIN;

  // ID is an instance tag only.
  if (ID < 0) begin : g_id_tag_only
  end

  // Handshake: a stage-N result moves out when out_valid && out_ready; the
  // whole pipe advances unless the last stage holds data that is not taken.
  // in_ready is that advance term, so an input is accepted on in_valid && in_ready.
  logic                 w_advance;
  logic [NUM_STAGE:1]   r_v;
  logic signed [PW-1:0] w_a, w_b, w_prod, w_pre;
  logic signed [EW-1:0] w_ext;
  logic [DW-1:0]        w_low, w_res;
  logic [EW-1:0]        w_back;
  logic                 w_lossy;
  logic [DW-1:0]        r_dout;
  logic                 r_lossy;
  logic                 r_ovf;

  assign w_advance = !(r_v[NUM_STAGE] && !out_ready);

  assign w_a    = {{(PW-din0_WIDTH){S0 & din0[din0_WIDTH-1]}}, din0};
  assign w_b    = {{(PW-din1_WIDTH){S1 & din1[din1_WIDTH-1]}}, din1};
  assign w_prod = w_a * w_b;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_v <= '0;
    end else if (w_advance) begin
      r_v[1] <= in_valid;
      for (int k = 2; k <= NUM_STAGE; k++) begin
        r_v[k] <= r_v[k-1];
      end
    end
  end

  // Stages 1..N-1 carry the exact product; stage N holds the formatted result.
  if (NUM_STAGE > 1) begin : g_prod_pipe
    logic signed [PW-1:0] r_prod [1:PS];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int k = 1; k <= PS; k++) begin
          r_prod[k] <= '0;
        end
      end else if (w_advance) begin
        r_prod[1] <= w_prod;
        for (int k = 2; k <= PS; k++) begin
          r_prod[k] <= r_prod[k-1];
        end
      end
    end

    assign w_pre = r_prod[PS];
  end else begin : g_prod_direct
    assign w_pre = w_prod;
  end

  // A result is lossy when re-extending its low DW bits does not give back
  // the exact product.
  assign w_ext   = EW'(w_pre);
  assign w_low   = w_ext[DW-1:0];
  assign w_back  = OUT_SIGNED ? EW'($signed(w_low)) : EW'(w_low);
  assign w_lossy = (w_back != w_ext);

  always_comb begin
    w_res = w_low;
    if (DO_SAT && w_lossy) begin
      if (OUT_SIGNED) begin
        w_res = w_ext[EW-1] ? SMIN : SMAX;
      end else begin
        w_res = '1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_dout  <= '0;
      r_lossy <= 1'b0;
    end else if (w_advance) begin
      r_dout  <= w_res;
      r_lossy <= w_lossy;
    end
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_v[NUM_STAGE] && out_ready && r_lossy) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign in_ready  = w_advance;
  assign dout      = r_dout;
  assign out_valid = r_v[NUM_STAGE];
  assign busy      = |r_v;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_case_2_mul_pipe_hs.sv
// Bench for case_2_mul_pipe_hs: three instances (signed wrap, signed saturate,
// mixed-sign wide output) share one stimulus stream and one reference model.
module tb_case_2_mul_pipe_hs;

  logic       ap_clk    = 1'b0;
  logic       ap_rst_n  = 1'b0;
  logic [5:0] din0      = '0;
  logic [2:0] din1      = '0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b1;
  logic       ovf_clr   = 1'b0;

  logic       in_ready_a, in_ready_b, in_ready_c;
  logic [5:0] dout_a, dout_b;
  logic [9:0] dout_c;
  logic       out_valid_a, out_valid_b, out_valid_c;
  logic       busy_a, busy_b, busy_c;
  logic       ovf_a, ovf_b, ovf_c;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  case_2_mul_pipe_hs #(.ID(1), .NUM_STAGE(3), .din0_WIDTH(6), .din1_WIDTH(3),
    .dout_WIDTH(6), .SIGNED0(1), .SIGNED1(1), .SAT(0)) u_dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(din0), .din1(din1),
    .in_valid(in_valid), .in_ready(in_ready_a), .dout(dout_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .busy(busy_a),
    .ovf(ovf_a), .ovf_clr(ovf_clr));

  case_2_mul_pipe_hs #(.ID(2), .NUM_STAGE(3), .din0_WIDTH(6), .din1_WIDTH(3),
    .dout_WIDTH(6), .SIGNED0(1), .SIGNED1(1), .SAT(1)) u_dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(din0), .din1(din1),
    .in_valid(in_valid), .in_ready(in_ready_b), .dout(dout_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b),
    .ovf(ovf_b), .ovf_clr(ovf_clr));

  case_2_mul_pipe_hs #(.ID(3), .NUM_STAGE(3), .din0_WIDTH(6), .din1_WIDTH(3),
    .dout_WIDTH(10), .SIGNED0(0), .SIGNED1(1), .SAT(0)) u_dut_c (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(din0), .din1(din1),
    .in_valid(in_valid), .in_ready(in_ready_c), .dout(dout_c),
    .out_valid(out_valid_c), .out_ready(out_ready), .busy(busy_c),
    .ovf(ovf_c), .ovf_clr(ovf_clr));

  // ---------------- clock / reset ----------------
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Exact integer product, then range test / clamp / modulo 2^dw.
  function automatic logic [10:0] ref_mul(input logic [5:0] a, input logic [2:0] b,
                                          input bit s0, input bit s1, input int dw,
                                          input bit sat);
    longint av, bv, p, lo, hi, one;
    logic   lossy;
    logic [9:0] d;
    one = 1;
    if (s0) av = longint'($signed(a)); else av = longint'(a);
    if (s1) bv = longint'($signed(b)); else bv = longint'(b);
    p = av * bv;
    if (s0 || s1) begin
      hi = (one << (dw - 1)) - 1;
      lo = -(one << (dw - 1));
    end else begin
      hi = (one << dw) - 1;
      lo = 0;
    end
    lossy = (p < lo) || (p > hi);
    if (lossy && sat) p = (p < lo) ? lo : hi;
    d = 10'(p & ((one << dw) - 1));
    return {lossy, d};
  endfunction

  // ---------------- scoreboard ----------------
  // Every accepted input needs exactly three pipeline advances to reach the
  // output; the head item is presented once it has made all three.
  typedef struct {
    logic [5:0] da; logic la;
    logic [5:0] db; logic lb;
    logic [9:0] dc; logic lc;
    int         age;
  } item_t;

  item_t      exp_q[$];
  logic [2:0] m_ovf = '0;
  bit         m_exp_ov, m_adv, m_fire;
  logic [10:0] m_r;
  item_t      m_it;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      exp_q.delete();
      m_ovf = '0;
      chk("rst_out_valid", {out_valid_a, out_valid_b, out_valid_c}, 3'b000);
      chk("rst_busy", {busy_a, busy_b, busy_c}, 3'b000);
      chk("rst_ovf", {ovf_a, ovf_b, ovf_c}, 3'b000);
      chk("rst_in_ready", {in_ready_a, in_ready_b, in_ready_c}, 3'b111);
      chk("rst_dout", {dout_a, dout_b, dout_c}, 22'd0);
    end else begin
      m_exp_ov = (exp_q.size() > 0) && (exp_q[0].age == 3);
      m_adv    = !(m_exp_ov && !out_ready);
      chk("in_ready", {in_ready_a, in_ready_b, in_ready_c}, {3{m_adv}});
      chk("out_valid", {out_valid_a, out_valid_b, out_valid_c}, {3{m_exp_ov}});
      chk("busy", {busy_a, busy_b, busy_c}, {3{exp_q.size() > 0}});
      chk("ovf", {ovf_a, ovf_b, ovf_c}, m_ovf);
      if (m_exp_ov) begin
        chk("dout_a", dout_a, exp_q[0].da);
        chk("dout_b", dout_b, exp_q[0].db);
        chk("dout_c", dout_c, exp_q[0].dc);
      end
      m_fire = m_exp_ov && out_ready;
      if (m_fire) begin
        m_ovf[2] = exp_q[0].la ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf[2]);
        m_ovf[1] = exp_q[0].lb ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf[1]);
        m_ovf[0] = exp_q[0].lc ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf[0]);
        void'(exp_q.pop_front());
        n_out++;
      end else if (ovf_clr) begin
        m_ovf = '0;
      end
      if (m_adv) begin
        for (int i = 0; i < exp_q.size(); i++) begin
          m_it = exp_q[i];
          m_it.age = m_it.age + 1;
          exp_q[i] = m_it;
        end
        if (in_valid) begin
          m_r = ref_mul(din0, din1, 1'b1, 1'b1, 6, 1'b0);
          m_it.da = m_r[5:0]; m_it.la = m_r[10];
          m_r = ref_mul(din0, din1, 1'b1, 1'b1, 6, 1'b1);
          m_it.db = m_r[5:0]; m_it.lb = m_r[10];
          m_r = ref_mul(din0, din1, 1'b0, 1'b1, 10, 1'b0);
          m_it.dc = m_r[9:0]; m_it.lc = m_r[10];
          m_it.age = 1;
          exp_q.push_back(m_it);
        end
      end
    end
  end

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [5:0] a;  logic [2:0] b;
    logic [5:0] da; logic la;
    logic [5:0] db; logic lb;
    logic [9:0] dc; logic lc;
  } vec_t;

  vec_t vecs[8];
  int   acc_cnt, cyc, n0;
  bit   acc;

  initial begin
    // a, b, wrap result/lossy, saturated result/lossy, mixed-sign result/lossy
    vecs[0] = '{6'd59, 3'd3, 6'h31, 1'b0, 6'h31, 1'b0, 10'h0B1, 1'b0}; // -5*3
    vecs[1] = '{6'd32, 3'd4, 6'h00, 1'b1, 6'h1F, 1'b1, 10'h380, 1'b0}; // -32*-4
    vecs[2] = '{6'd63, 3'd4, 6'h04, 1'b0, 6'h04, 1'b0, 10'h304, 1'b0}; // 63u*-4
    vecs[3] = '{6'd31, 3'd3, 6'h1D, 1'b1, 6'h1F, 1'b1, 10'h05D, 1'b0};
    vecs[4] = '{6'd31, 3'd4, 6'h04, 1'b1, 6'h20, 1'b1, 10'h384, 1'b0};
    vecs[5] = '{6'd0,  3'd4, 6'h00, 1'b0, 6'h00, 1'b0, 10'h000, 1'b0};
    vecs[6] = '{6'd32, 3'd1, 6'h20, 1'b0, 6'h20, 1'b0, 10'h020, 1'b0};
    vecs[7] = '{6'd32, 3'd3, 6'h20, 1'b1, 6'h20, 1'b1, 10'h060, 1'b0};

    repeat (3) step();
    ap_rst_n = 1'b1;
    step();

    // Single transactions: exact latency, value and sticky flag.
    foreach (vecs[i]) begin
      din0 = vecs[i].a; din1 = vecs[i].b;
      in_valid = 1'b1; out_ready = 1'b1; ovf_clr = 1'b1;
      step();
      in_valid = 1'b0; ovf_clr = 1'b0;
      step();
      chk("lat_early", out_valid_a, 1'b0);
      step();
      chk("lat_valid", out_valid_a, 1'b1);
      chk("vec_dout_a", dout_a, vecs[i].da);
      chk("vec_dout_b", dout_b, vecs[i].db);
      chk("vec_dout_c", dout_c, vecs[i].dc);
      step();
      chk("vec_ovf_a", ovf_a, vecs[i].la);
      chk("vec_ovf_b", ovf_b, vecs[i].lb);
      chk("vec_ovf_c", ovf_c, vecs[i].lc);
    end

    // Clear coinciding with a lossy consumption: set wins, then clear alone.
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    din0 = 6'd32; din1 = 3'd4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("ovf_seq_valid", out_valid_a, 1'b1);
    ovf_clr = 1'b1;
    step();
    chk("ovf_set_wins", ovf_a, 1'b1);
    step();
    chk("ovf_clr_alone", ovf_a, 1'b0);
    ovf_clr = 1'b0;
    step();

    // Ten back-to-back inputs with out_ready low for cycles 4-6.
    n0 = n_out; acc_cnt = 0; cyc = 0;
    din0 = 6'($urandom); din1 = 3'($urandom);
    while (acc_cnt < 10 && cyc < 100) begin
      in_valid  = 1'b1;
      out_ready = !(cyc >= 4 && cyc <= 6);
      #1;
      acc = in_ready_a;
      if (cyc == 5) chk("stall_in_ready", in_ready_a, 1'b0);
      step();
      cyc++;
      if (acc) begin
        acc_cnt++;
        din0 = 6'($urandom); din1 = 3'($urandom);
      end
    end
    chk("stream_accepted", acc_cnt, 10);
    drain();
    chk("stream_count", n_out - n0, 10);

    // Randomised traffic with random backpressure and clears.
    for (int c = 0; c < 600; c++) begin
      din0      = 6'($urandom);
      din1      = 3'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      step();
    end
    drain();

    // Reset with all three stages full discards everything at once.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din0 = vecs[i+1].a; din1 = vecs[i+1].b; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("full_out_valid", out_valid_a, 1'b1);
    chk("full_in_ready", in_ready_a, 1'b0);
    ap_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid_a, 1'b0);
    chk("async_rst_busy", busy_a, 1'b0);
    chk("async_rst_dout", dout_a, 6'h00);
    chk("async_rst_ready", in_ready_a, 1'b1);
    step();
    step();
    ap_rst_n  = 1'b1;
    out_ready = 1'b1;
    din0 = vecs[0].a; din1 = vecs[0].b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_c1", out_valid_a, 1'b0);
    step();
    chk("post_rst_c2", out_valid_a, 1'b0);
    step();
    chk("post_rst_c3", out_valid_a, 1'b1);
    chk("post_rst_dout", dout_a, 6'h31);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
